// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   state_e : access sequencer states
//   owner_e : which requester currently holds the memory port
//   BE_ALL  : byte enables for a full-word read
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that times the fixed memory read latency.
//   Clk      : system clock, rising edge
//   Rst      : synchronous active-high reset, clears the count
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one; holds at zero
//   zero     : count is zero
module mem_lat_counter #(
    parameter  int MEM_LAT = 2,
    localparam int CNT_W   = $clog2(MEM_LAT + 1)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single-port unified memory between instruction fetch
// (I) and load/store (D). Each access runs IDLE -> ISSUE -> WAIT -> ACK;
// all outputs are registered.
//   Clk, Rst                    : clock, synchronous active-high reset
//   IReq/IAddr -> IAck/IRdata   : fetch handshake, read only
//   DReq/DWe/DAddr/DWdata/DBe
//              -> DAck/DRdata   : load/store handshake
//   MemEn/MemWe/MemAddr/MemWdata/MemBe -> memory, MemRdata <- memory
//
// state | meaning
// IDLE  | arbitrate, latch the winner's fields
// ISSUE | MemEn high for this cycle only, load latency counter
// WAIT  | count down; at zero capture MemRdata and raise owner's Ack
// ACK   | Ack visible; requests ignored since Req is still held
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 2,
    parameter int MAX_D_RUN = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAddr,
    output logic              IAck,
    output logic [DATA_W-1:0] IRdata,
    input  logic              DReq,
    input  logic              DWe,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWdata,
    input  logic [3:0]        DBe,
    output logic              DAck,
    output logic [DATA_W-1:0] DRdata,
    output logic              MemEn,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWdata,
    output logic [3:0]        MemBe,
    input  logic [DATA_W-1:0] MemRdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int RUN_W = $clog2(MAX_D_RUN + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_D_RUN);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("mem_port_arbiter: DATA_W must be 32");
    end
    if (MEM_LAT < 1 || MEM_LAT > 8) begin : g_bad_mem_lat
        $error("mem_port_arbiter: MEM_LAT must be 1..8");
    end
    if (MAX_D_RUN < 1 || MAX_D_RUN > 15) begin : g_bad_max_d_run
        $error("mem_port_arbiter: MAX_D_RUN must be 1..15");
    end

    state_e            state_d, state_q;
    owner_e            own_d, own_q;
    logic [RUN_W-1:0]  d_run_d, d_run_q;
    logic              mem_en_d, mem_en_q;
    logic              mem_we_d, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
    logic [3:0]        mem_be_d, mem_be_q;
    logic              i_ack_d, i_ack_q;
    logic              d_ack_d, d_ack_q;
    logic [DATA_W-1:0] i_rdata_d, i_rdata_q;
    logic [DATA_W-1:0] d_rdata_d, d_rdata_q;

    logic cnt_load, cnt_dec, cnt_zero;
    logic d_wins;

    mem_lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_cnt (
        .Clk      (Clk),
        .Rst      (Rst),
        .load     (cnt_load),
        .load_val (LAT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // D is the older instruction and normally wins; after MAX_D_RUN
    // back-to-back D grants with a fetch waiting, the fetch gets one turn.
    assign d_wins = DReq && !(IReq && (d_run_q == RUN_MAX));

    always_comb begin
        state_d     = state_q;
        own_d       = own_q;
        d_run_d     = d_run_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!IReq) begin
                    d_run_d = '0;
                end
                if (IReq || DReq) begin
                    state_d  = ISSUE;
                    mem_en_d = 1'b1;
                    if (d_wins) begin
                        own_d       = OWN_D;
                        mem_we_d    = DWe;
                        mem_addr_d  = DAddr;
                        mem_wdata_d = DWdata;
                        mem_be_d    = DWe ? DBe : BE_ALL;
                        if (IReq && (d_run_q != RUN_MAX)) begin
                            d_run_d = d_run_q + 1'b1;
                        end
                    end else begin
                        own_d      = OWN_I;
                        mem_addr_d = IAddr;
                        mem_be_d   = BE_ALL;
                        d_run_d    = '0;
                    end
                end
            end
            ISSUE: begin
                cnt_load = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                if (cnt_zero) begin
                    state_d = ACK;
                    if (own_q == OWN_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = MemRdata;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = MemRdata;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            own_q       <= OWN_D;
            d_run_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            d_run_q     <= d_run_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign IAck     = i_ack_q;
    assign IRdata   = i_rdata_q;
    assign DAck     = d_ack_q;
    assign DRdata   = d_rdata_q;
    assign MemEn    = mem_en_q;
    assign MemWe    = mem_we_q;
    assign MemAddr  = mem_addr_q;
    assign MemWdata = mem_wdata_q;
    assign MemBe    = mem_be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        Clk;
    logic        Rst;
    logic        IReq;
    logic [31:0] IAddr;
    logic        IAck;
    logic [31:0] IRdata;
    logic        DReq;
    logic        DWe;
    logic [31:0] DAddr;
    logic [31:0] DWdata;
    logic [3:0]  DBe;
    logic        DAck;
    logic [31:0] DRdata;
    logic        MemEn;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWdata;
    logic [3:0]  MemBe;
    logic [31:0] MemRdata;

    int n_pass  = 0;
    int n_total = 0;

    mem_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_LAT   (2),
        .MAX_D_RUN (4)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .IReq     (IReq),
        .IAddr    (IAddr),
        .IAck     (IAck),
        .IRdata   (IRdata),
        .DReq     (DReq),
        .DWe      (DWe),
        .DAddr    (DAddr),
        .DWdata   (DWdata),
        .DBe      (DBe),
        .DAck     (DAck),
        .DRdata   (DRdata),
        .MemEn    (MemEn),
        .MemWe    (MemWe),
        .MemAddr  (MemAddr),
        .MemWdata (MemWdata),
        .MemBe    (MemBe),
        .MemRdata (MemRdata)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Memory contents: a few fixed words, everything else addr ^ pattern.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        case (a)
            32'h0040_0000: mem_data = 32'h2008_000A;
            32'h0040_0010: mem_data = 32'h8C0A_0004;
            32'h1001_0000: mem_data = 32'h1122_3344;
            default:       mem_data = a ^ 32'hA5A5_5A5A;
        endcase
    endfunction

    // Fixed two-cycle read pipe; outside the valid cycle the bus carries junk.
    logic        p1_v, p2_v;
    logic [31:0] p1_a, p2_a;
    always @(posedge Clk) begin
        p1_v <= MemEn && !MemWe;
        p1_a <= MemAddr;
        p2_v <= p1_v;
        p2_a <= p1_a;
    end
    assign MemRdata = p2_v ? mem_data(p2_a) : 32'h0BAD_0BAD;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        Rst = 1'b1; IReq = 1'b0; IAddr = '0; DReq = 1'b0; DWe = 1'b0;
        DAddr = '0; DWdata = '0; DBe = '0;
        cyc(3);

        // Reset values
        chk("rst_iack", IAck, 0);   chk("rst_dack", DAck, 0);
        chk("rst_men", MemEn, 0);   chk("rst_mwe", MemWe, 0);
        chk("rst_maddr", MemAddr, 0); chk("rst_mwdata", MemWdata, 0);
        chk("rst_mbe", MemBe, 0);   chk("rst_irdata", IRdata, 0);
        chk("rst_drdata", DRdata, 0);
        Rst = 1'b0;
        cyc();

        // Single fetch, grant at T
        IReq = 1'b1; IAddr = 32'h0040_0000;
        cyc();  // T+1
        chk("f_men", MemEn, 1); chk("f_mwe", MemWe, 0);
        chk("f_maddr", MemAddr, 32'h0040_0000); chk("f_mbe", MemBe, 4'hF);
        cyc();  // T+2
        chk("f_men_t2", MemEn, 0); chk("f_iack_t2", IAck, 0);
        cyc();  // T+3
        chk("f_iack_t3", IAck, 0);
        cyc();  // T+4
        chk("f_iack", IAck, 1); chk("f_irdata", IRdata, 32'h2008_000A);
        chk("f_dack", DAck, 0);
        IReq = 1'b0;
        cyc();  // T+5
        chk("f_iack_t5", IAck, 0);

        // Simultaneous I and D load, grant at T
        IReq = 1'b1; IAddr = 32'h0040_0010;
        DReq = 1'b1; DWe = 1'b0; DAddr = 32'h1001_0000;
        cyc();  // T+1
        chk("s_men_d", MemEn, 1); chk("s_maddr_d", MemAddr, 32'h1001_0000);
        chk("s_mwe_d", MemWe, 0); chk("s_mbe_d", MemBe, 4'hF);
        cyc(3); // T+4
        chk("s_dack", DAck, 1); chk("s_drdata", DRdata, 32'h1122_3344);
        chk("s_iack_t4", IAck, 0);
        DReq = 1'b0;
        cyc();  // T+5
        chk("s_men_t5", MemEn, 0); chk("s_dack_t5", DAck, 0);
        cyc();  // T+6
        chk("s_men_i", MemEn, 1); chk("s_maddr_i", MemAddr, 32'h0040_0010);
        cyc(3); // T+9
        chk("s_iack", IAck, 1); chk("s_irdata", IRdata, 32'h8C0A_0004);
        chk("s_dack_t9", DAck, 0); chk("s_drdata_hold", DRdata, 32'h1122_3344);
        IReq = 1'b0;
        cyc();  // T+10, IDLE

        // Store with byte enables; fields change after grant
        DReq = 1'b1; DWe = 1'b1; DAddr = 32'h1001_0004;
        DWdata = 32'hDEAD_BEEF; DBe = 4'b0011;
        cyc();  // T+1 (ISSUE)
        chk("w_men", MemEn, 1); chk("w_mwe", MemWe, 1);
        chk("w_maddr", MemAddr, 32'h1001_0004);
        chk("w_mwdata", MemWdata, 32'hDEAD_BEEF); chk("w_mbe", MemBe, 4'b0011);
        DWdata = 32'h0; DBe = 4'hF; DAddr = 32'h0;
        cyc();  // T+2
        chk("w_men_t2", MemEn, 0); chk("w_mwe_t2", MemWe, 0);
        chk("w_maddr_hold", MemAddr, 32'h1001_0004);
        cyc(2); // T+4
        chk("w_dack", DAck, 1); chk("w_iack", IAck, 0);
        chk("w_irdata_hold", IRdata, 32'h8C0A_0004);
        DReq = 1'b0; DWe = 1'b0;
        cyc();

        // Starvation guard: D and I held; each access takes 5 cycles.
        // Slots 0-3 D, slot 4 I, slots 5-8 D (d_run restarted), slot 9 I.
        IReq = 1'b1; IAddr = 32'h0040_0020;
        DReq = 1'b1; DWe = 1'b0; DAddr = 32'h1001_0008;
        for (int k = 1; k < 50; k++) begin
            int  g;
            int  ph;
            logic is_i;
            cyc();
            g    = k / 5;
            ph   = k % 5;
            is_i = (g == 4) || (g == 9);
            chk($sformatf("sv_men_%0d", k), MemEn, (ph == 1) ? 1 : 0);
            if (ph == 1) begin
                chk($sformatf("sv_maddr_%0d", k), MemAddr,
                    !is_i ? 32'h1001_0008 : (g == 4) ? 32'h0040_0020 : 32'h0040_0024);
            end
            chk($sformatf("sv_iack_%0d", k), IAck, (ph == 4 && is_i) ? 1 : 0);
            chk($sformatf("sv_dack_%0d", k), DAck, (ph == 4 && !is_i) ? 1 : 0);
            if (k == 24) begin
                chk("sv_irdata1", IRdata, mem_data(32'h0040_0020));
                IAddr = 32'h0040_0024;
            end
            if (k == 49) begin
                chk("sv_irdata2", IRdata, mem_data(32'h0040_0024));
                IReq = 1'b0; DReq = 1'b0;
            end
        end
        cyc();  // IDLE, R

        // Reset during WAIT of a D load
        DReq = 1'b1; DWe = 1'b0; DAddr = 32'h1001_0010;
        cyc();  // R+1 ISSUE
        chk("r_men", MemEn, 1);
        cyc();  // R+2 WAIT
        Rst = 1'b1;
        cyc();  // R+3
        chk("r_dack", DAck, 0);   chk("r_men0", MemEn, 0);
        chk("r_maddr", MemAddr, 0); chk("r_drdata", DRdata, 0);
        chk("r_irdata", IRdata, 0); chk("r_mbe", MemBe, 0);
        Rst = 1'b0; DReq = 1'b0;
        IReq = 1'b1; IAddr = 32'h0040_0000;
        cyc();  // R+4
        chk("r_men_i", MemEn, 1); chk("r_maddr_i", MemAddr, 32'h0040_0000);
        chk("r_dack2", DAck, 0);
        cyc(2); // R+6
        chk("r_iack_early", IAck, 0); chk("r_dack3", DAck, 0);
        cyc();  // R+7
        chk("r_iack", IAck, 1); chk("r_irdata_i", IRdata, 32'h2008_000A);
        IReq = 1'b0;
        cyc();  // IDLE, W

        // Fetch withdrawn the cycle after ISSUE
        IReq = 1'b1; IAddr = 32'h0040_0030;
        cyc();  // W+1
        chk("x_men", MemEn, 1); chk("x_maddr", MemAddr, 32'h0040_0030);
        cyc();  // W+2
        IReq = 1'b0;
        cyc(2); // W+4
        chk("x_iack", IAck, 1); chk("x_irdata", IRdata, mem_data(32'h0040_0030));
        for (int k = 5; k < 9; k++) begin
            cyc();
            chk($sformatf("x_men_%0d", k), MemEn, 0);
            chk($sformatf("x_iack_%0d", k), IAck, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
